io_port_responder: RTL and testbench

- Responder end of the processor's PicoBlaze-style I/O bus (port ID, write strobe, read strobe, read data); sits between processor_top and rs232_uart on the clk100 domain.
- Decodes port IDs and drives a registered read-data mux.
- Generates the UART RX read-acknowledge.
- Buffers processor TX writes in a small FIFO that drains into the UART when its TX buffer has room.
- Provides a status port and one general-purpose output register.

---
 rtl/io_map_pkg.sv | 26 ++
 rtl/io_tx_fifo.sv | 69 ++++++
 rtl/io_port_responder.sv | 181 ++++++++++++++++++
 tb/tb_io_port_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg
// Shared I/O map for the processor's port-mapped bus: default port IDs,
// status register bit positions and the TX drain FSM state encoding.
// Ports: none (package only).
package io_map_pkg;

   // Default port IDs; the responder takes these as parameter defaults.
   localparam logic [7:0] DEF_STATUS_PORT = 8'h00;
   localparam logic [7:0] DEF_UART_PORT   = 8'h01;
   localparam logic [7:0] DEF_GPO_PORT    = 8'h02;

   // Status register bit positions (bits 7..5 read as zero).
   localparam int ST_RX_PRESENT = 0;
   localparam int ST_FIFO_FULL  = 1;
   localparam int ST_FIFO_EMPTY = 2;
   localparam int ST_OVERFLOW   = 3;
   localparam int ST_TX_FULL    = 4;

   // TX drain FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } drain_state_t;

endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo
// Small circular-buffer FIFO with read/write pointers and an occupancy count.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and reported on 'overflow' for that cycle.
// A pop while empty is ignored.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   push, push_data   write request and data
//   pop               remove head entry
//   head_data         current head entry (valid when !empty)
//   full, empty       occupancy flags
//   count             entries held, 0..DEPTH
//   overflow          one-cycle flag: push was dropped
module io_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;
   logic             push_ok;

   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign head_data = mem[rd_ptr];

   // A same-cycle pop frees the slot the push needs.
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign overflow = push && !push_ok;

   // DEPTH is a power of two, so pointers wrap by natural rollover.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/io_port_responder.sv
// io_port_responder
// Responder end of the PicoBlaze-style I/O bus between the processor and
// rs232_uart. Decodes port IDs, returns registered read data, acknowledges
// UART RX reads, stages TX bytes in a FIFO drained into the UART, and holds
// a general-purpose output register plus a sticky TX overflow flag.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   IO_port_ID              port ID from processor
//   IO_write_data           write data from processor
//   IO_write_strobe         one-cycle write strobe
//   IO_read_strobe          one-cycle read strobe
//   IO_read_data            registered read data (valid 1 cycle after port ID)
//   uart_rx_data            UART received byte
//   uart_rx_data_present    UART has received data
//   uart_read_rx_data_ack   one-cycle pop pulse to UART RX
//   uart_tx_data            byte to UART TX (holds last value)
//   uart_write_tx_data      one-cycle write pulse to UART TX
//   uart_tx_buffer_full     UART TX buffer full
//   gpo                     general-purpose output register
//   tx_overflow             sticky TX overflow flag
module io_port_responder
   import io_map_pkg::*;
#(
   parameter logic [7:0] STATUS_PORT   = DEF_STATUS_PORT,
   parameter logic [7:0] UART_PORT     = DEF_UART_PORT,
   parameter logic [7:0] GPO_PORT      = DEF_GPO_PORT,
   parameter int         TX_FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] IO_port_ID,
   input  logic [7:0] IO_write_data,
   input  logic       IO_write_strobe,
   input  logic       IO_read_strobe,
   output logic [7:0] IO_read_data,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_rx_data_present,
   output logic       uart_read_rx_data_ack,
   output logic [7:0] uart_tx_data,
   output logic       uart_write_tx_data,
   input  logic       uart_tx_buffer_full,
   output logic [7:0] gpo,
   output logic       tx_overflow
);

   localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

   drain_state_t    state;
   drain_state_t    state_next;

   logic            fifo_push;
   logic            fifo_pop;
   logic [7:0]      fifo_head;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic            fifo_overflow;

   logic            load_tx;
   logic            ovf_clear;
   logic [7:0]      status_byte;
   logic [7:0]      read_mux;

   // ---------------- write decode ----------------
   assign fifo_push = IO_write_strobe && (IO_port_ID == UART_PORT);
   assign ovf_clear = IO_write_strobe && (IO_port_ID == STATUS_PORT)
                      && IO_write_data[ST_OVERFLOW];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpo <= '0;
      end else if (IO_write_strobe && (IO_port_ID == GPO_PORT)) begin
         gpo <= IO_write_data;
      end
   end

   // Set wins over a same-cycle clear so a lost byte is never hidden.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_overflow <= 1'b0;
      end else if (fifo_overflow) begin
         tx_overflow <= 1'b1;
      end else if (ovf_clear) begin
         tx_overflow <= 1'b0;
      end
   end

   // ---------------- read path ----------------
   always_comb begin
      status_byte                = '0;
      status_byte[ST_RX_PRESENT] = uart_rx_data_present;
      status_byte[ST_FIFO_FULL]  = fifo_full;
      status_byte[ST_FIFO_EMPTY] = fifo_empty;
      status_byte[ST_OVERFLOW]   = tx_overflow;
      status_byte[ST_TX_FULL]    = uart_tx_buffer_full;
   end

   always_comb begin
      read_mux = 8'h00;
      if (IO_port_ID == STATUS_PORT)     read_mux = status_byte;
      else if (IO_port_ID == UART_PORT)  read_mux = uart_rx_data;
      else if (IO_port_ID == GPO_PORT)   read_mux = gpo;
   end

   // Ack is sent even when RX is empty; the UART ignores an empty pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         IO_read_data          <= '0;
         uart_read_rx_data_ack <= 1'b0;
      end else begin
         IO_read_data          <= read_mux;
         uart_read_rx_data_ack <= IO_read_strobe && (IO_port_ID == UART_PORT);
      end
   end

   // ---------------- TX staging FIFO ----------------
   io_tx_fifo #(
      .DEPTH (TX_FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (IO_write_data),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .overflow  (fifo_overflow)
   );

   // ---------------- drain FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // HOLD gives the UART a cycle to update tx_buffer_full before the next
   // decision, so the drain runs at most one byte per three cycles.
   always_comb begin
      state_next         = state;
      uart_write_tx_data = 1'b0;
      fifo_pop           = 1'b0;
      load_tx            = 1'b0;
      case (state)
         IDLE: begin
            if ((fifo_count != '0) && !uart_tx_buffer_full) begin
               load_tx    = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            uart_write_tx_data = 1'b1;
            fifo_pop           = 1'b1;
            state_next         = HOLD;
         end
         HOLD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The head is captured on entry to ISSUE; it cannot change before the
   // pop, so the byte presented with the write pulse is the head byte and
   // it stays on the bus afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uart_tx_data <= '0;
      end else if (load_tx) begin
         uart_tx_data <= fifo_head;
      end
   end

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder
// Directed bench for io_port_responder: reset state, TX drain order and
// pacing, overflow set/clear, RX read/ack, GPO and unmapped reads,
// full-plus-pop acceptance, and reset in the middle of a drain.
module tb_io_port_responder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] IO_port_ID = 8'h10;
   logic [7:0] IO_write_data = 8'h00;
   logic       IO_write_strobe = 1'b0;
   logic       IO_read_strobe = 1'b0;
   logic [7:0] IO_read_data;
   logic [7:0] uart_rx_data = 8'h00;
   logic       uart_rx_data_present = 1'b0;
   logic       uart_read_rx_data_ack;
   logic [7:0] uart_tx_data;
   logic       uart_write_tx_data;
   logic       uart_tx_buffer_full = 1'b0;
   logic [7:0] gpo;
   logic       tx_overflow;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ack_cnt = 0;
   logic [7:0] exp_q[$];
   int         pulse_cyc[$];

   io_port_responder dut (
      .clk                   (clk),
      .reset                 (reset),
      .IO_port_ID            (IO_port_ID),
      .IO_write_data         (IO_write_data),
      .IO_write_strobe       (IO_write_strobe),
      .IO_read_strobe        (IO_read_strobe),
      .IO_read_data          (IO_read_data),
      .uart_rx_data          (uart_rx_data),
      .uart_rx_data_present  (uart_rx_data_present),
      .uart_read_rx_data_ack (uart_read_rx_data_ack),
      .uart_tx_data          (uart_tx_data),
      .uart_write_tx_data    (uart_write_tx_data),
      .uart_tx_buffer_full   (uart_tx_buffer_full),
      .gpo                   (gpo),
      .tx_overflow           (tx_overflow)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [7:0] exp_byte;
      if (uart_read_rx_data_ack) ack_cnt++;
      if (uart_write_tx_data) begin
         pulse_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL tx_unexpected observed=%0h expected=none", uart_tx_data);
            end
         end else begin
            exp_byte = exp_q.pop_front();
            check("tx_byte", uart_tx_data, exp_byte);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic io_write(input logic [7:0] port, input logic [7:0] data);
      IO_port_ID      = port;
      IO_write_data   = data;
      IO_write_strobe = 1'b1;
      tick(1);
      IO_write_strobe = 1'b0;
      IO_port_ID      = 8'h10;
   endtask

   // Port held two cycles, strobe in the second; data sampled in strobe cycle.
   task automatic io_read(input logic [7:0] port, output logic [7:0] data);
      IO_port_ID = port;
      tick(1);
      IO_read_strobe = 1'b1;
      data = IO_read_data;
      tick(1);
      IO_read_strobe = 1'b0;
      IO_port_ID     = 8'h10;
   endtask

   task automatic wait_pulse(input string tag);
      int n;
      n = 0;
      while (!uart_write_tx_data && n < 20) begin
         tick(1);
         n++;
      end
      check(tag, uart_write_tx_data, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] rd;
      int         acks0;

      // Reset state
      #12;
      check("rst_read_data", IO_read_data, 8'h00);
      check("rst_gpo", gpo, 8'h00);
      check("rst_overflow", tx_overflow, 1'b0);
      check("rst_ack", uart_read_rx_data_ack, 1'b0);
      check("rst_tx_write", uart_write_tx_data, 1'b0);
      check("rst_tx_data", uart_tx_data, 8'h00);
      tick(1);
      reset = 1'b0;
      tick(2);
      io_read(8'h00, rd);
      check("status_after_reset", rd, 8'h04);

      // TX drain: two bytes, pulses three cycles apart
      pulse_cyc.delete();
      exp_q.push_back(8'h41);
      exp_q.push_back(8'h42);
      io_write(8'h01, 8'h41);
      io_write(8'h01, 8'h42);
      tick(12);
      check("drain_pulse_count", pulse_cyc.size(), 2);
      if (pulse_cyc.size() == 2)
         check("drain_spacing", pulse_cyc[1] - pulse_cyc[0], 3);
      check("drain_exp_left", exp_q.size(), 0);
      io_read(8'h00, rd);
      check("status_drained", rd, 8'h04);

      // Overflow: five writes into a four-entry FIFO while UART is full
      uart_tx_buffer_full = 1'b1;
      for (int i = 0; i < 5; i++) io_write(8'h01, 8'h50 + 8'(i));
      check("overflow_flag", tx_overflow, 1'b1);
      io_read(8'h00, rd);
      check("status_overflow", rd, 8'h1A);
      io_write(8'h00, 8'h08);
      check("overflow_cleared", tx_overflow, 1'b0);
      io_read(8'h00, rd);
      check("status_cleared", rd, 8'h12);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h50 + 8'(i));
      uart_tx_buffer_full = 1'b0;
      tick(20);
      check("overflow_exp_left", exp_q.size(), 0);
      io_read(8'h00, rd);
      check("status_after_ovf_drain", rd, 8'h04);

      // RX read and ack
      uart_rx_data         = 8'h5A;
      uart_rx_data_present = 1'b1;
      acks0 = ack_cnt;
      IO_port_ID = 8'h01;
      tick(1);
      IO_read_strobe = 1'b1;
      check("rx_read_data", IO_read_data, 8'h5A);
      check("rx_ack_early", uart_read_rx_data_ack, 1'b0);
      tick(1);
      IO_read_strobe = 1'b0;
      IO_port_ID     = 8'h10;
      check("rx_ack", uart_read_rx_data_ack, 1'b1);
      tick(1);
      check("rx_ack_drop", uart_read_rx_data_ack, 1'b0);
      tick(2);
      check("rx_ack_count", ack_cnt - acks0, 1);
      uart_rx_data_present = 1'b0;

      // GPO and unmapped port
      io_write(8'h02, 8'hC3);
      check("gpo_load", gpo, 8'hC3);
      io_read(8'h02, rd);
      check("gpo_readback", rd, 8'hC3);
      io_read(8'h7F, rd);
      check("unmapped_read", rd, 8'h00);

      // Full FIFO with a push in the same cycle as the drain pop
      uart_tx_buffer_full = 1'b1;
      for (int i = 0; i < 4; i++) io_write(8'h01, 8'h60 + 8'(i));
      io_read(8'h00, rd);
      check("status_full", rd, 8'h12);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
      exp_q.push_back(8'h99);
      uart_tx_buffer_full = 1'b0;
      wait_pulse("fullpop_issue_seen");
      IO_port_ID      = 8'h01;
      IO_write_data   = 8'h99;
      IO_write_strobe = 1'b1;
      tick(1);
      IO_write_strobe = 1'b0;
      IO_port_ID      = 8'h10;
      check("fullpop_no_overflow", tx_overflow, 1'b0);
      tick(30);
      check("fullpop_exp_left", exp_q.size(), 0);
      check("fullpop_overflow_end", tx_overflow, 1'b0);

      // Reset in the middle of a drain with three bytes queued
      uart_tx_buffer_full = 1'b1;
      io_write(8'h01, 8'hA0);
      io_write(8'h01, 8'hA1);
      io_write(8'h01, 8'hA2);
      uart_tx_buffer_full = 1'b0;
      wait_pulse("middrain_issue_seen");
      check("middrain_head", uart_tx_data, 8'hA0);
      reset = 1'b1;
      #1;
      check("midrst_tx_write", uart_write_tx_data, 1'b0);
      check("midrst_tx_data", uart_tx_data, 8'h00);
      check("midrst_gpo", gpo, 8'h00);
      check("midrst_read_data", IO_read_data, 8'h00);
      check("midrst_ack", uart_read_rx_data_ack, 1'b0);
      check("midrst_overflow", tx_overflow, 1'b0);
      tick(2);
      reset = 1'b0;
      pulse_cyc.delete();
      tick(10);
      check("midrst_no_pulse", pulse_cyc.size(), 0);
      io_read(8'h00, rd);
      check("midrst_status", rd, 8'h04);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
